// File: rtl/axi_lite_status_regs.sv
// AXI4-Lite status register block: ID, version, scratch, control
// and a free-running 64-bit cycle counter with a latched high word.
module axi_lite_status_regs #(
    parameter logic [31:0] ID_VALUE = 32'hC0DE_0001,
    parameter logic [31:0] VERSION  = 32'h0001_0000,
    parameter int          ADDR_W   = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);

    localparam logic [ADDR_W-1:0] OFF_ID   = ADDR_W'('h000);
    localparam logic [ADDR_W-1:0] OFF_VER  = ADDR_W'('h004);
    localparam logic [ADDR_W-1:0] OFF_SCR  = ADDR_W'('h008);
    localparam logic [ADDR_W-1:0] OFF_LO   = ADDR_W'('h00C);
    localparam logic [ADDR_W-1:0] OFF_HI   = ADDR_W'('h010);
    localparam logic [ADDR_W-1:0] OFF_CTRL = ADDR_W'('h014);
    localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(3);
    localparam logic [1:0]        OKAY     = 2'b00;
    localparam logic [1:0]        SLVERR   = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    r_state_t          r_state;
    w_state_t          w_state;
    logic [31:0]       scratch;
    logic              ctrl_en;
    logic [63:0]       cnt;
    logic [31:0]       hi_shadow;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] ar_off;
    logic [ADDR_W-1:0] aw_off;
    logic [31:0]       rd_data;
    logic              rd_err;
    logic              wr_err;
    logic              wr_fire;

    assign ar_off  = s_axi_araddr & WORD_MSK;
    assign aw_off  = awaddr_q & WORD_MSK;
    assign wr_fire = (w_state == W_IDLE) && aw_held && w_held;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (ar_off)
            OFF_ID:   rd_data = ID_VALUE;
            OFF_VER:  rd_data = VERSION;
            OFF_SCR:  rd_data = scratch;
            OFF_LO:   rd_data = cnt[31:0];
            OFF_HI:   rd_data = hi_shadow;
            OFF_CTRL: rd_data = {31'b0, ctrl_en};
            default:  rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        wr_err = 1'b0;
        case (aw_off)
            OFF_ID, OFF_VER, OFF_SCR,
            OFF_LO, OFF_HI, OFF_CTRL: wr_err = 1'b0;
            default:                  wr_err = 1'b1;
        endcase
    end

    // Read channel; a CNT_LO read snapshots the high word for CNT_HI.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= OKAY;
            hi_shadow     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rdata   <= rd_data;
                        s_axi_rresp   <= rd_err ? SLVERR : OKAY;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_RESP;
                        if (ar_off == OFF_LO)
                            hi_shadow <= cnt[63:32];
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write channel; AW and W are captured independently in any order.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= OKAY;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_fire) begin
                        s_axi_bvalid  <= 1'b1;
                        s_axi_bresp   <= wr_err ? SLVERR : OKAY;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        w_state       <= W_RESP;
                    end else begin
                        s_axi_awready <= !aw_held &&
                            !(s_axi_awvalid && s_axi_awready);
                        s_axi_wready  <= !w_held &&
                            !(s_axi_wvalid && s_axi_wready);
                        if (s_axi_awvalid && s_axi_awready) begin
                            aw_held  <= 1'b1;
                            awaddr_q <= s_axi_awaddr;
                        end
                        if (s_axi_wvalid && s_axi_wready) begin
                            w_held  <= 1'b1;
                            wdata_q <= s_axi_wdata;
                            wstrb_q <= s_axi_wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Register file and counter; a clear request beats the increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= '0;
            ctrl_en <= 1'b1;
            cnt     <= '0;
        end else begin
            if (ctrl_en)
                cnt <= cnt + 64'd1;
            if (wr_fire) begin
                case (aw_off)
                    OFF_SCR: begin
                        for (int i = 0; i < 4; i++)
                            if (wstrb_q[i])
                                scratch[8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                    OFF_CTRL: begin
                        if (wstrb_q[0]) begin
                            ctrl_en <= wdata_q[0];
                            if (wdata_q[1])
                                cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_status_regs.sv
// Scoreboard bench for axi_lite_status_regs: stimulus queues expected
// responses, a negedge monitor pops them on each R/B handshake.
module tb_axi_lite_status_regs;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [11:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;

    always #5 clock = ~clock;

    axi_lite_status_regs dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          chk;
    } rexp_t;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    logic [31:0] rlog[$];
    int          total = 0;
    int          bad = 0;

    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        rexp_t e;
        logic [1:0] eb;
        if (rvalid && rready) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 1, 0);
            end else begin
                e = rq.pop_front();
                rlog.push_back(rdata);
                check("rresp", 64'(rresp), 64'(e.resp));
                if (e.chk)
                    check("rdata", 64'(rdata), 64'(e.data));
            end
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) begin
                check("b_unexpected", 1, 0);
            end else begin
                eb = bq.pop_front();
                check("bresp", 64'(bresp), 64'(eb));
            end
        end
    end

    // Called at a negedge; returns at a negedge.
    task automatic rd(input logic [11:0] a, input logic [31:0] d,
                      input logic [1:0] r, input bit c,
                      output logic [31:0] got);
        int n = 0;
        rq.push_back('{d, r, c});
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!arready) begin
            check("ar_timeout", 1, 0);
            arvalid = 1'b0;
            got = '0;
            return;
        end
        @(posedge clock);
        #1 arvalid = 1'b0;
        @(negedge clock);
        check("rd_latency", 64'(rvalid), 1);
        n = 0;
        while (rvalid && n < 50) begin
            @(negedge clock);
            n++;
        end
        got = (rlog.size() > 0) ? rlog[$] : '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] r,
                      input int aw_dly, input int w_dly,
                      input int bhold);
        int n = 0;
        bq.push_back(r);
        if (bhold > 0)
            bready = 1'b0;
        fork
            begin
                int k = 0;
                repeat (aw_dly) @(negedge clock);
                awaddr  = a;
                awvalid = 1'b1;
                while (!awready && k < 50) begin
                    @(negedge clock);
                    k++;
                end
                if (!awready)
                    check("aw_timeout", 1, 0);
                @(posedge clock);
                #1 awvalid = 1'b0;
            end
            begin
                int k = 0;
                repeat (w_dly) @(negedge clock);
                wdata  = d;
                wstrb  = s;
                wvalid = 1'b1;
                while (!wready && k < 50) begin
                    @(negedge clock);
                    k++;
                end
                if (!wready)
                    check("w_timeout", 1, 0);
                @(posedge clock);
                #1 wvalid = 1'b0;
            end
        join
        do begin
            @(negedge clock);
            n++;
        end while (!bvalid && n < 50);
        if (!bvalid) begin
            check("b_timeout", 1, 0);
            bready = 1'b1;
            return;
        end
        if (bhold > 0) begin
            repeat (bhold) @(negedge clock);
            check("bvalid_held", 64'(bvalid), 1);
            @(posedge clock);
            #1 bready = 1'b1;
        end
        n = 0;
        while (bvalid && n < 50) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        logic [31:0] v0, v1;
        repeat (3) @(negedge clock);
        check("rst_arready", 64'(arready), 0);
        check("rst_awready", 64'(awready), 0);
        check("rst_wready",  64'(wready),  0);
        check("rst_rvalid",  64'(rvalid),  0);
        check("rst_bvalid",  64'(bvalid),  0);
        check("rst_rdata",   64'(rdata),   0);
        check("rst_resp",    64'({rresp, bresp}), 0);
        reset = 1'b0;
        @(negedge clock);

        rd(12'h000, 32'hC0DE_0001, OK, 1, v0);
        rd(12'h004, 32'h0001_0000, OK, 1, v0);
        rd(12'h014, 32'h0000_0001, OK, 1, v0);

        wr(12'h008, 32'hA5A5_5A5A, 4'hF, OK, 0, 0, 0);
        wr(12'h008, 32'h0000_00FF, 4'h1, OK, 0, 0, 0);
        rd(12'h008, 32'hA5A5_5AFF, OK, 1, v0);

        wr(12'h008, 32'h1234_5678, 4'hF, OK, 3, 0, 5);
        rd(12'h008, 32'h1234_5678, OK, 1, v0);
        wr(12'h00A, 32'hCAFE_F00D, 4'hF, OK, 0, 0, 5);
        rd(12'h008, 32'hCAFE_F00D, OK, 1, v0);

        wr(12'h000, 32'hFFFF_FFFF, 4'hF, OK, 0, 0, 0);
        rd(12'h000, 32'hC0DE_0001, OK, 1, v0);

        rd(12'h00C, 32'h0, OK, 0, v0);
        rd(12'h00C, 32'h0, OK, 0, v1);
        check("cnt_runs", 64'(v1 > v0), 1);
        wr(12'h014, 32'h0000_0002, 4'hF, OK, 0, 0, 0);
        rd(12'h014, 32'h0, OK, 1, v0);
        rd(12'h00C, 32'h0, OK, 0, v0);
        check("cnt_small", 64'(v0 < 32'd10), 1);
        rd(12'h010, 32'h0, OK, 1, v1);
        wr(12'h014, 32'h0000_0000, 4'hF, OK, 0, 0, 0);
        rd(12'h00C, 32'h0, OK, 0, v0);
        rd(12'h00C, 32'h0, OK, 0, v1);
        check("cnt_frozen", 64'(v1), 64'(v0));
        wr(12'h014, 32'h0000_0001, 4'hF, OK, 0, 0, 0);
        rd(12'h00C, 32'h0, OK, 0, v0);
        rd(12'h00C, 32'h0, OK, 0, v1);
        check("cnt_resumed", 64'(v1 > v0), 1);

        rd(12'h100, 32'h0, SE, 1, v0);
        wr(12'h100, 32'hDEAD_BEEF, 4'hF, SE, 0, 0, 0);
        rd(12'h008, 32'hCAFE_F00D, OK, 1, v0);

        rready  = 1'b0;
        araddr  = 12'h008;
        arvalid = 1'b1;
        @(posedge clock);
        #1 arvalid = 1'b0;
        @(negedge clock);
        check("pre_rst_rvalid", 64'(rvalid), 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_rvalid", 64'(rvalid), 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_arready", 64'(arready), 1);
        check("post_rst_rvalid", 64'(rvalid), 0);
        rready = 1'b1;
        rd(12'h008, 32'h0, OK, 1, v0);
        rd(12'h014, 32'h1, OK, 1, v0);

        repeat (4) @(negedge clock);
        check("rq_drained", 64'(rq.size()), 0);
        check("bq_drained", 64'(bq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
